// File: rtl/toggle_ctrl.sv
// Programmable T flip-flop toggle generator with q-state mirror and sticky mismatch flag.
// Latency: busy from the start edge; first t pulse `period` cycles after start; done one cycle after the last t cycle.
// Backpressure: none; start is sampled only in IDLE, stop aborts RUN. TOGGLE_CTRL_FREERUN_EN makes burst=0 free-run.
module toggle_ctrl #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               ck,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst,
  input  logic               q,
  output logic               t,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulses,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef TOGGLE_CTRL_FREERUN_EN
  localparam logic FREERUN = 1'b1;
`else
  localparam logic FREERUN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   per_m1, per_nxt;      // latched period-1, reload value of the interval counter
  logic [BURST_W-1:0] burst_r, burst_nxt;
  logic [BURST_W-1:0] pulses_nxt;
  logic [BURST_W-1:0] p_inc;
  logic               t_nxt, done_nxt, err_nxt;
  logic               exp_q, exp_nxt;       // expected state of the downstream flip-flop

  assign busy  = (state == RUN);
  assign p_inc = pulses + BURST_ONE;

  // Next-state, counter, pulse and monitor logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    per_nxt    = per_m1;
    burst_nxt  = burst_r;
    pulses_nxt = pulses;
    t_nxt      = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = err;
    // The flip-flop toggles at the edge that ends a t cycle; mirror it here.
    exp_nxt    = exp_q ^ t;

    // Compare pre-edge q against the mirror only while a burst is live.
    if ((state == RUN || state == DONE) && (q != exp_q)) begin
      err_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start && !stop) begin
          // period=0 behaves as period=1, i.e. a reload value of 0.
          per_nxt    = (period == '0) ? '0 : (period - CNT_ONE);
          cnt_nxt    = (period == '0) ? '0 : (period - CNT_ONE);
          burst_nxt  = burst;
          pulses_nxt = '0;
          err_nxt    = 1'b0;
          exp_nxt    = q;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (!FREERUN && burst_r == '0) begin
          state_nxt = DONE;
        end else if (cnt == '0) begin
          cnt_nxt    = per_m1;
          t_nxt      = 1'b1;
          pulses_nxt = p_inc;
          // burst_r=0 only reaches here in free-run mode, where pulses wraps instead of finishing.
          if (p_inc == burst_r && burst_r != '0) begin
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      per_m1  <= '0;
      burst_r <= '0;
      pulses  <= '0;
      t       <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      per_m1  <= per_nxt;
      burst_r <= burst_nxt;
      pulses  <= pulses_nxt;
      t       <= t_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      exp_q   <= exp_nxt;
    end
  end

endmodule

// File: tb/tb_toggle_ctrl.sv
// Bench for toggle_ctrl with a behavioural T flip-flop attached downstream.
// Per-cycle expectations are derived from the period/burst timing formula and queued at start.
// Multi-cycle corner cases (burst=0, start+stop, q mismatch, async reset) are hand sequences.
module tb_toggle_ctrl;
  localparam int CNT_W   = 8;
  localparam int BURST_W = 8;

  logic               ck = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [CNT_W-1:0]   period = '0;
  logic [BURST_W-1:0] burst = '0;
  logic               q;
  logic               t, busy, done, err;
  logic [BURST_W-1:0] pulses;

  logic q_ff;
  logic stuck = 1'b0;
  int   q_toggles = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    int per;
    int bur;
    int stop_c;     // cycle index whose starting edge samples stop (0 = no stop)
    int start2_c;   // cycle index whose starting edge sees a stray start (0 = none)
    int exp_pulses;
  } vec_t;

  typedef struct {
    logic t;
    logic busy;
    logic done;
  } obs_t;

  vec_t vecs[5];
  obs_t sb[$];

  toggle_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .ck(ck), .rstn(rstn), .start(start), .stop(stop), .period(period),
    .burst(burst), .q(q), .t(t), .busy(busy), .done(done), .pulses(pulses), .err(err)
  );

  always #5 ck = ~ck;

  // Downstream T flip-flop; stuck forces a broken q to the controller
  always @(posedge ck or negedge rstn) begin
    if (!rstn) q_ff <= 1'b0;
    else if (t) q_ff <= ~q_ff;
  end
  assign q = stuck ? 1'b0 : q_ff;

  always @(q_ff) q_toggles++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int pe, last, n, q_base;
    bit tpos;
    obs_t e;
    pe   = (v.per == 0) ? 1 : v.per;
    last = pe * v.bur;
    n    = (v.stop_c > 0) ? v.stop_c + 2 : last + 3;
    @(negedge ck);
    period = v.per[CNT_W-1:0];
    burst  = v.bur[BURST_W-1:0];
    start  = 1'b1;
    for (int c = 0; c < n; c++) begin
      tpos   = (c >= pe) && (c % pe == 0) && (c / pe <= v.bur);
      e.t    = tpos && (v.stop_c == 0 || c < v.stop_c);
      e.busy = (c < last) && (v.stop_c == 0 || c < v.stop_c);
      e.done = (v.stop_c == 0) && (c == last + 1);
      sb.push_back(e);
    end
    @(negedge ck);
    start  = 1'b0;
    q_base = q_toggles;
    for (int c = 0; c < n; c++) begin
      e = sb.pop_front();
      check($sformatf("vec%0d cyc%0d t/busy/done", idx, c), {29'd0, t, busy, done},
            {29'd0, e.t, e.busy, e.done});
      stop = (v.stop_c > 0) && (c + 1 == v.stop_c);
      if (v.start2_c > 0 && c + 1 == v.start2_c) begin
        start  = 1'b1;
        period = 8'd7;
        burst  = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge ck);
    end
    stop  = 1'b0;
    start = 1'b0;
    check($sformatf("vec%0d pulses", idx), 32'(pulses), 32'(v.exp_pulses));
    check($sformatf("vec%0d err", idx), 32'(err), 32'd0);
    check($sformatf("vec%0d q toggles", idx), 32'(q_toggles - q_base), 32'(v.exp_pulses));
  endtask

  initial begin
    int tc, dc;
    logic [BURST_W-1:0] held;

    //            per bur stop start2 pulses
    vecs[0] = '{3,  4,  0,   0,     4};   // basic burst
    vecs[1] = '{1,  5,  0,   0,     5};   // back-to-back
    vecs[2] = '{4,  10, 9,   0,     2};   // abort after 2nd pulse
    vecs[3] = '{0,  3,  0,   0,     3};   // period 0 acts as 1
    vecs[4] = '{2,  3,  0,   2,     3};   // start during RUN ignored

    // Reset state
    repeat (2) @(negedge ck);
    check("reset outputs", {24'd0, t, busy, done, err, pulses[3:0]}, 32'd0);
    check("reset pulses", 32'(pulses), 32'd0);
    rstn = 1'b1;
    @(negedge ck);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // start and stop together in IDLE: nothing happens
    held = pulses;
    @(negedge ck);
    period = 8'd1; burst = 8'd2; start = 1'b1; stop = 1'b1;
    @(negedge ck);
    start = 1'b0; stop = 1'b0;
    tc = 0;
    for (int c = 0; c < 4; c++) begin
      tc += int'(t) + int'(busy) + int'(done);
      @(negedge ck);
    end
    check("start+stop activity", 32'(tc), 32'd0);
    check("start+stop pulses held", 32'(pulses), 32'(held));

`ifdef TOGGLE_CTRL_FREERUN_EN
    // burst=0 free-runs with period 1 until stop; pulses wraps
    @(negedge ck);
    period = 8'd1; burst = 8'd0; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    dc = 0;
    for (int c = 0; c < 262; c++) begin
      dc += int'(done);
      if (c == 259) check("freerun busy", 32'(busy), 32'd1);
      stop = (c + 1 == 260);
      @(negedge ck);
    end
    stop = 1'b0;
    check("freerun done count", 32'(dc), 32'd0);
    check("freerun pulses wrap", 32'(pulses), 32'd3);
    check("freerun busy after stop", 32'(busy), 32'd0);
`else
    // burst=0 completes at once with no t pulse
    @(negedge ck);
    period = 8'd2; burst = 8'd0; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    check("burst0 busy at start", 32'(busy), 32'd1);
    tc = 0; dc = 0;
    for (int c = 0; c < 5; c++) begin
      tc += int'(t);
      dc += int'(done);
      @(negedge ck);
    end
    check("burst0 t count", 32'(tc), 32'd0);
    check("burst0 done count", 32'(dc), 32'd1);
    check("burst0 pulses", 32'(pulses), 32'd0);
`endif

    // q stuck at 0: err from cycle 4, sticky until the next start
    stuck = 1'b1;
    @(negedge ck);
    period = 8'd2; burst = 8'd3; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("mismatch err cyc%0d", c), 32'(err), (c >= 4) ? 32'd1 : 32'd0);
      @(negedge ck);
    end
    stuck = 1'b0;
    period = 8'd1; burst = 8'd1; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    check("err cleared by start", 32'(err), 32'd0);
    repeat (4) @(negedge ck);
    check("err after clean burst", 32'(err), 32'd0);

    // Asynchronous reset in the middle of a t cycle with err set
    stuck = 1'b1;
    period = 8'd2; burst = 8'd10; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    repeat (6) @(negedge ck);
    check("pre-reset t/busy/err", {29'd0, t, busy, err}, 32'd7);
    #2 rstn = 1'b0;
    #1;
    check("async reset outputs", {24'd0, t, busy, done, err, 4'd0}, 32'd0);
    check("async reset pulses", 32'(pulses), 32'd0);
    stuck = 1'b0;
    @(negedge ck);
    rstn = 1'b1;
    @(negedge ck);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
